// File: rtl/game_pkg.sv
// Shared dialog constants: contact colour codes, keypad codes, speaker and dialog-state enums.
// Latency: n/a (declarations only); backpressure: n/a.
package game_pkg;

    localparam logic [11:0] CONTACT_WOMAN  = 12'h00F;
    localparam logic [11:0] CONTACT_WIZARD = 12'h0FF;
    localparam logic [11:0] CONTACT_DOOR   = 12'hFF0;

    localparam logic [3:0] KEY_NONE    = 4'hF;
    localparam logic [3:0] KEY_1       = 4'h1;
    localparam logic [3:0] KEY_ACCEPT  = KEY_1;
    localparam logic [3:0] KEY_DECLINE = 4'h2;
    localparam logic [3:0] KEY_NEXT    = 4'hA;

    typedef enum logic [1:0] {
        SPK_NONE   = 2'd0,
        SPK_WOMAN  = 2'd1,
        SPK_WIZARD = 2'd2,
        SPK_DOOR   = 2'd3
    } speaker_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        TALK   = 2'd1,
        CHOICE = 2'd2,
        CLOSE  = 2'd3
    } dlg_state_t;

    function automatic speaker_t decode_contact(input logic [11:0] code);
        case (code)
            CONTACT_WOMAN:  return SPK_WOMAN;
            CONTACT_WIZARD: return SPK_WIZARD;
            CONTACT_DOOR:   return SPK_DOOR;
            default:        return SPK_NONE;
        endcase
    endfunction

    // SPK_NONE maps to a code no real pixel colour is compared against while a speaker is latched.
    function automatic logic [11:0] speaker_code(input speaker_t spk);
        case (spk)
            SPK_WOMAN:  return CONTACT_WOMAN;
            SPK_WIZARD: return CONTACT_WIZARD;
            SPK_DOOR:   return CONTACT_DOOR;
            default:    return 12'h000;
        endcase
    endfunction

endpackage

// File: rtl/game_dialog_ctrl_if.sv
// Bundle of the dialog controller's keypad/contact inputs and renderer/quest outputs.
// Latency: n/a (wiring only); backpressure: none.
interface game_dialog_ctrl_if import game_pkg::*; ();

    logic [3:0]  key;
    logic        frame_tick;
    logic [11:0] contact;
    logic        dialog_active;
    speaker_t    speaker;
    logic [2:0]  page;
    logic        text_bank;
    logic        choice;
    logic        refused;
    logic        item;
    logic        door;

    modport master (
        output key, frame_tick, contact,
        input  dialog_active, speaker, page, text_bank, choice, refused, item, door
    );

    modport slave (
        input  key, frame_tick, contact,
        output dialog_active, speaker, page, text_bank, choice, refused, item, door
    );

endinterface

// File: rtl/key_edge.sv
// Keypad press detector: one press per key-down, holding a key never repeats.
// Latency: press is combinational from key against the registered previous key; backpressure: none.
module key_edge import game_pkg::*; (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] key,
    output logic       press,
    output logic [3:0] press_code
);

    logic [3:0] key_prev;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) key_prev <= KEY_NONE;
        else      key_prev <= key;
    end

    assign press      = (key != KEY_NONE) && (key_prev == KEY_NONE);
    assign press_code = key;

endmodule

// File: rtl/game_dialog_ctrl.sv
// Dialog sequencer: contact opens a paged dialog, keypad advances it, final choice sets quest flags.
// Latency: input sampled in cycle N shows on the registered outputs in N+1; backpressure: none.
module game_dialog_ctrl import game_pkg::*; #(
    parameter int PAGES_WOMAN    = 2,
    parameter int PAGES_WIZARD   = 3,
    parameter int PAGES_DOOR     = 1,
    parameter int TIMEOUT_FRAMES = 600
) (
    input  logic               clk,
    input  logic               rst,
    game_dialog_ctrl_if.slave  bus
);

    dlg_state_t state_q, state_d;
    speaker_t   spk_q, spk_d;
    logic [2:0] page_q, page_d;
    logic [9:0] tcnt_q, tcnt_d;
    logic       item_q, item_d;
    logic       door_q, door_d;
    logic       refused_q, refused_d;
    logic       active_q, choice_q, bank_q;

    logic       press;
    logic [3:0] press_code;
    speaker_t   contact_spk;
    logic       contact_held;

    key_edge u_key_edge (
        .clk        (clk),
        .rst        (rst),
        .key        (bus.key),
        .press      (press),
        .press_code (press_code)
    );

    function automatic logic [2:0] last_page(input speaker_t spk);
        case (spk)
            SPK_WOMAN:  return 3'(PAGES_WOMAN - 1);
            SPK_WIZARD: return 3'(PAGES_WIZARD - 1);
            SPK_DOOR:   return 3'(PAGES_DOOR - 1);
            default:    return 3'd0;
        endcase
    endfunction

    assign contact_spk  = decode_contact(bus.contact);
    assign contact_held = (bus.contact == speaker_code(spk_q));

    // Within an open dialog: contact loss beats a press, which beats the timeout.
    always_comb begin
        state_d   = state_q;
        spk_d     = spk_q;
        page_d    = page_q;
        tcnt_d    = tcnt_q;
        item_d    = item_q;
        door_d    = door_q;
        refused_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (contact_spk != SPK_NONE) begin
                    spk_d   = contact_spk;
                    page_d  = 3'd0;
                    tcnt_d  = 10'd0;
                    state_d = (last_page(contact_spk) == 3'd0) ? CHOICE : TALK;
                end
            end
            TALK, CHOICE: begin
                if (!contact_held) begin
                    state_d = IDLE;
                    spk_d   = SPK_NONE;
                end else if (press) begin
                    tcnt_d = 10'd0;
                    if (state_q == TALK) begin
                        if (press_code == KEY_NEXT) begin
                            page_d = page_q + 3'd1;
                            if (page_q + 3'd1 == last_page(spk_q)) state_d = CHOICE;
                        end
                    end else if (press_code == KEY_ACCEPT) begin
                        if (spk_q == SPK_WIZARD) item_d = 1'b1;
                        if (spk_q == SPK_DOOR) begin
                            if (item_q) door_d    = 1'b1;
                            else        refused_d = 1'b1;
                        end
                        state_d = CLOSE;
                    end else if (press_code == KEY_DECLINE) begin
                        state_d = CLOSE;
                    end
                end else if (tcnt_q >= 10'(TIMEOUT_FRAMES)) begin
                    state_d = CLOSE;
                end else if (bus.frame_tick && (tcnt_q != 10'h3FF)) begin
                    tcnt_d = tcnt_q + 10'd1;
                end
            end
            CLOSE: begin
                if (!contact_held) begin
                    state_d = IDLE;
                    spk_d   = SPK_NONE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            spk_q     <= SPK_NONE;
            page_q    <= 3'd0;
            tcnt_q    <= 10'd0;
            item_q    <= 1'b0;
            door_q    <= 1'b0;
            refused_q <= 1'b0;
            active_q  <= 1'b0;
            choice_q  <= 1'b0;
            bank_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            spk_q     <= spk_d;
            page_q    <= page_d;
            tcnt_q    <= tcnt_d;
            item_q    <= item_d;
            door_q    <= door_d;
            refused_q <= refused_d;
            active_q  <= (state_d == TALK) || (state_d == CHOICE);
            choice_q  <= (state_d == CHOICE);
            bank_q    <= (spk_d == SPK_WIZARD);
        end
    end

    assign bus.dialog_active = active_q;
    assign bus.speaker       = spk_q;
    assign bus.page          = page_q;
    assign bus.text_bank     = bank_q;
    assign bus.choice        = choice_q;
    assign bus.refused       = refused_q;
    assign bus.item          = item_q;
    assign bus.door          = door_q;

endmodule

// File: doc/game_dialog_ctrl.md
# game_dialog_ctrl

Dialog sequencer for the game content layer. Detects player contact with an NPC or door from the colour code under the player, opens a multi-page dialog, and advances pages on keypad presses. Resolves the final accept/decline choice into the sticky `item`/`door` quest flags. Drives the page/bank selection consumed by the dialog text renderer and its character ROMs; it does no pixel work itself.

## Interface
Parameters:
- `PAGES_WOMAN`, default 2: page count of the woman dialog (1..8).
- `PAGES_WIZARD`, default 3: page count of the wizard dialog (1..8).
- `PAGES_DOOR`, default 1: page count of the door dialog (1..8).
- `TIMEOUT_FRAMES`, default 600: frames with no key press before auto-close (1..1023).

Ports:
- `clk`  in  1  system clock (pixel clock domain).
- `rst`  in  1  reset, asynchronous, active-low.
- `key`  in  4  keypad code, `KEY_NONE` when idle.
- `frame_tick`  in  1  one-cycle pulse per frame (start of vblank).
- `contact`  in  12  colour code of map pixel under the player.
- `dialog_active`  out  1  renderer shows the dialog box.
- `speaker`  out  2  latched speaker (`SPK_NONE/WOMAN/WIZARD/DOOR`).
- `page`  out  3  current page index, 0-based.
- `text_bank`  out  1  1 = second character ROM (wizard), else 0.
- `choice`  out  1  last page reached, awaiting accept/decline.
- `refused`  out  1  one-cycle pulse: door accepted without item.
- `item`  out  1  sticky: item received from wizard.
- `door`  out  1  sticky: door opened.

## Operation
- Press event: `key != KEY_NONE` while registered `key_prev == KEY_NONE`. Holding a key yields exactly one event.
- Contact decode: `CONTACT_WOMAN` 12'h00F, `CONTACT_WIZARD` 12'h0FF, `CONTACT_DOOR` 12'hFF0. Any other value means no contact.
- IDLE: on a decoded contact, latch `speaker`, clear `page` and the timeout counter, go to TALK.
- TALK: a `KEY_NEXT` press does `page+1`. Entering page `last = PAGES_x-1` goes to CHOICE. If `PAGES_x == 1`, IDLE goes directly to CHOICE. Other keys are ignored.
- CHOICE, on `KEY_ACCEPT`:
  - wizard sets `item`;
  - door with `item=1` sets `door`;
  - door with `item=0` pulses `refused`;
  - woman changes no flag.
  - Then go to CLOSE.
- CHOICE, on `KEY_DECLINE`: go to CLOSE.
- TALK/CHOICE exits:
  - `contact` no longer equal to the latched speaker code → abort to IDLE.
  - Timeout counter reaches `TIMEOUT_FRAMES` → CLOSE.
- Timeout counter: 10-bit, increments on `frame_tick`, saturates. Cleared on every press event.
- CLOSE: `dialog_active=0`. Hold until `contact` differs from the latched speaker code, then go to IDLE and clear `speaker`. Standing still therefore never reopens the dialog.
- `item` and `door` are never cleared except by reset. `door` is only set if `item` was already 1 in the same cycle.
- `text_bank = (speaker == SPK_WIZARD)`. `dialog_active = 1` in TALK and CHOICE only. `choice = 1` in CHOICE only.

## Timing
- All outputs are registered. Reset values: `speaker=SPK_NONE`, `page=0`, every 1-bit output 0, state IDLE, `key_prev=KEY_NONE`.
- Latency: contact or press sampled in cycle N → outputs updated in N+1.
- Priority in TALK/CHOICE within one cycle: contact lost > press event > timeout.
- A press event and `frame_tick` in the same cycle: the counter clears; it does not increment.
- A press in IDLE/CLOSE is consumed by `key_prev` but has no effect. A key held while a dialog opens does not advance it.
- Reset asserted mid-dialog: all outputs go to reset values immediately (asynchronous). No partial flag update.
- `page` never exceeds `PAGES_x-1`. Extra `KEY_NEXT` presses in CHOICE are ignored.

## Structure
- Shared package `game_pkg`:
  - contact constants `CONTACT_WOMAN/WIZARD/DOOR`;
  - `speaker_t` enum;
  - state enum `dlg_state_t {IDLE, TALK, CHOICE, CLOSE}`;
  - `KEY_NONE`, `KEY_NEXT`, `KEY_ACCEPT`, `KEY_DECLINE` (`KEY_ACCEPT` equals the existing `key_1`).
- Sub-module `key_edge`: registers `key`, outputs `press` and `press_code`. It is reused by other menus.
- FSM, page counter and timeout counter stay in the top module.

## Test plan
- Woman, 2 pages: `contact=12'h00F`, one `KEY_NEXT`, then `KEY_ACCEPT` → `dialog_active` pulse sequence page 0, 1, `choice=1`, then CLOSE. `item=0`, `door=0`.
- Wizard then door: wizard dialog with accept → `item=1`, `text_bank=1` during the dialog. Door with accept → `door=1`, `refused` stays 0.
- Door without item: accept → `refused` high for exactly 1 cycle, `door=0`. CLOSE holds until `contact` changes, then IDLE.
- Held key: `KEY_NEXT` held for 50 cycles in TALK → `page` increments once.
- Timeout: `TIMEOUT_FRAMES=4`, no keys for 4 `frame_tick` → CLOSE. A press on tick 3 restarts the count.
- Abort plus reset: contact lost and a press in the same cycle → IDLE, page unchanged by the press. Reset asserted in CHOICE → all outputs 0 without waiting for a clock edge.
